key_pulse_multi: RTL

- Multi-channel successor to the single-key falling-edge pulse generator.
- Each of NUM_KEYS active-low pushbutton inputs passes through a 2-FF synchronizer and a per-channel debounce counter.
- Outputs per channel: registered one-cycle press pulse, one-cycle release pulse, and a debounced pressed level.
- Sits between board buttons and control logic (menu/mode FSMs) in the same clock domain.

---
 rtl/key_pulse_multi.sv | 128 ++++++++++++
 1 files changed

// File: rtl/key_pulse_multi.sv
// Multi-channel debounced key interface: per-channel 2-FF synchronizer, debounce counter,
// registered press/release pulses and pressed level. Define KEY_REPEAT_EN to add auto-repeat.
module key_pulse_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  localparam int MAX_A     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_LIMIT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;

  // Every counter limit minus one must be representable in CNT_W bits.
  if (MAX_LIMIT > (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for configured debounce/repeat limits");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        if (!s2_q[i]) press_d[i]   = 1'b1;
        else          release_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '1;
      s2_q      <= '1;
      stable_q  <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      // NOTE: the counter array is plain flops, so it is reset like any other state; a
      // reset that left counts behind could emit a pulse right after reset exit.
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= key_n;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      level_q   <= ~stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0]    hcnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    hcnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] armed_q, armed_d;   // first repeat already issued -> use period
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;

  always_comb begin
    armed_d  = armed_q;
    repeat_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hcnt_d[i] = hcnt_q[i];
      if (press_d[i] || release_d[i] || stable_q[i]) begin
        hcnt_d[i]  = '0;
        armed_d[i] = 1'b0;
      end else if (hcnt_q[i] == (armed_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
        repeat_d[i] = 1'b1;
        hcnt_d[i]   = '0;
        armed_d[i]  = 1'b1;
      end else begin
        hcnt_d[i] = hcnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= '0;
      repeat_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) hcnt_q[i] <= '0;
    end else begin
      armed_q  <= armed_d;
      repeat_q <= repeat_d;
      for (int i = 0; i < NUM_KEYS; i++) hcnt_q[i] <= hcnt_d[i];
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = '0;
`endif

endmodule
